dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 125 ++++++++++++
 tb/tb_dmem_resp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory response block: sequences one SRAM word access per MEM-stage request and stalls the
// pipeline until it completes. Optional misaligned-address trap via DMEM_RESP_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module dmem_resp #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TRANDATADDR,
    input  logic        SORL,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] MEMDATAI,
    output logic        DSTALL,
    output logic        SRAM_CE,
    output logic        SRAM_WE,
    output logic [29:0] SRAM_ADDR,
    output logic [31:0] SRAM_WDATA,
    input  logic [31:0] SRAM_RDATA,
    output logic        ADDRERR
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        sorl_q;
    logic [31:0] rdata_q;
    logic        aerr_q;
    logic        misaligned;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    assign misaligned = |DADDR[1:0];
`else
    // Byte offset is dropped: every access is a full word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^DADDR[1:0];
    assign misaligned      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (TRANDATADDR) begin
                    state_d = misaligned ? StDone : StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end
            end
            // The requesting instruction is still present here, so the request is ignored.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= 4'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            sorl_q  <= 1'b0;
            rdata_q <= 32'd0;
            aerr_q  <= 1'b0;
        end else begin
            aerr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (TRANDATADDR) begin
                        addr_q  <= DADDR[31:2];
                        wdata_q <= DATAO;
                        sorl_q  <= SORL;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        aerr_q  <= misaligned;
                    end
                end
                StAccess: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!sorl_q) begin
                        rdata_q <= SRAM_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // SRAM strobes are decoded from state so an async reset drops them without a clock.
    always_comb begin
        DSTALL     = 1'b0;
        SRAM_CE    = 1'b0;
        SRAM_WE    = 1'b0;
        SRAM_ADDR  = 30'd0;
        SRAM_WDATA = 32'd0;
        unique case (state_q)
            StIdle: DSTALL = TRANDATADDR;
            StAccess: begin
                DSTALL     = 1'b1;
                SRAM_CE    = 1'b1;
                SRAM_WE    = sorl_q;
                SRAM_ADDR  = addr_q;
                SRAM_WDATA = wdata_q;
            end
            default: ;
        endcase
    end

    assign MEMDATAI = rdata_q;
    assign ADDRERR  = aerr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp: one instance with WAIT_CYCLES=2, one with 0.
`timescale 1ns/1ps
module tb_dmem_resp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default wait states, read data driven directly by the bench.
    logic        req_a, sorl_a, stall_a, ce_a, we_a, aerr_a;
    logic [31:0] daddr_a, datao_a, md_a, wdata_a, rdata_a;
    logic [29:0] addr_a;

    // Instance B: zero wait states, backed by a small SRAM model.
    logic        req_b, sorl_b, stall_b, ce_b, we_b, aerr_b;
    logic [31:0] daddr_b, datao_b, md_b, wdata_b, rdata_b;
    logic [29:0] addr_b;
    logic [31:0] mem_b [0:255];
    int          n_writes_b = 0;

    dmem_resp dut_a (
        .clk(clk), .reset(reset), .TRANDATADDR(req_a), .SORL(sorl_a), .DADDR(daddr_a),
        .DATAO(datao_a), .MEMDATAI(md_a), .DSTALL(stall_a), .SRAM_CE(ce_a), .SRAM_WE(we_a),
        .SRAM_ADDR(addr_a), .SRAM_WDATA(wdata_a), .SRAM_RDATA(rdata_a), .ADDRERR(aerr_a)
    );

    dmem_resp #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .TRANDATADDR(req_b), .SORL(sorl_b), .DADDR(daddr_b),
        .DATAO(datao_b), .MEMDATAI(md_b), .DSTALL(stall_b), .SRAM_CE(ce_b), .SRAM_WE(we_b),
        .SRAM_ADDR(addr_b), .SRAM_WDATA(wdata_b), .SRAM_RDATA(rdata_b), .ADDRERR(aerr_b)
    );

    assign rdata_b = mem_b[addr_b[7:0]];
    always @(posedge clk) begin
        if (ce_b && we_b) begin
            mem_b[addr_b[7:0]] <= wdata_b;
            n_writes_b         <= n_writes_b + 1;
        end
    end

    // Drives one request on A, holding it through DONE, and measures what the SRAM side saw.
    task automatic access_a(input logic sorl, input logic [31:0] addr, input logic [31:0] wd,
                            output int n_stall, output int n_ce, output int n_we,
                            output int n_aerr, output int n_addr_chg, output int n_wd_bad,
                            output logic [29:0] first_addr, output logic [31:0] md_done,
                            output bit timeout);
        bit seen_ce;
        n_stall = 0; n_ce = 0; n_we = 0; n_aerr = 0; n_addr_chg = 0; n_wd_bad = 0;
        first_addr = '0; md_done = '0; timeout = 1'b1; seen_ce = 1'b0;
        req_a = 1'b1; sorl_a = sorl; daddr_a = addr; datao_a = wd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (aerr_a) n_aerr++;
            if (we_a) n_we++;
            if (ce_a) begin
                n_ce++;
                if (!seen_ce) first_addr = addr_a;
                else if (addr_a !== first_addr) n_addr_chg++;
                seen_ce = 1'b1;
                if (we_a && wdata_a !== wd) n_wd_bad++;
            end
            if (stall_a) n_stall++;
            else begin
                md_done = md_a;
                timeout = 1'b0;
            end
            @(negedge clk);
            if (!timeout) break;
        end
        req_a = 1'b0; daddr_a = 32'hFFFF_FFFF; datao_a = 32'h0;
        #1;
        if (aerr_a) n_aerr++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_a = 0; sorl_a = 0; daddr_a = 0; datao_a = 0; rdata_a = 0;
        req_b = 0; sorl_b = 0; daddr_b = 0; datao_b = 0;
        #2;
        checks++;
        if ({md_a, ce_a, we_a, addr_a, wdata_a, aerr_a, stall_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a: got md=%h ce=%b we=%b addr=%h wd=%h aerr=%b stall=%b, expected all 0",
                     md_a, ce_a, we_a, addr_a, wdata_a, aerr_a, stall_a);
        end
        checks++;
        if ({md_b, ce_b, we_b, addr_b, wdata_b, aerr_b, stall_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b: got md=%h ce=%b we=%b aerr=%b stall=%b, expected all 0",
                     md_b, ce_b, we_b, aerr_b, stall_b);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        daddr_a = 32'hA5A5_A5A7; datao_a = 32'h5A5A_5A5A; sorl_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({ce_a, we_a, addr_a, wdata_a, stall_a} !== '0) begin
                errors++;
                $display("FAIL idle_quiet[%0d]: got ce=%b we=%b addr=%h wd=%h stall=%b, expected 0",
                         i, ce_a, we_a, addr_a, wdata_a, stall_a);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        int ns, nc, nw, ne, nchg, nwd; logic [29:0] fa; logic [31:0] md; bit to;
        rdata_a = 32'hDEAD_BEEF;
        access_a(1'b0, 32'h0000_0010, 32'h0, ns, nc, nw, ne, nchg, nwd, fa, md, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL load_timeout: got %b expected 0", to); end
        checks++; if (ns != 4) begin errors++; $display("FAIL load_stall_len: got %0d expected 4", ns); end
        checks++; if (nc != 3) begin errors++; $display("FAIL load_ce_len: got %0d expected 3", nc); end
        checks++; if (nw != 0) begin errors++; $display("FAIL load_we_len: got %0d expected 0", nw); end
        checks++; if (fa !== 30'h4) begin errors++; $display("FAIL load_addr: got %h expected 4", fa); end
        checks++; if (nchg != 0) begin errors++; $display("FAIL load_addr_stable: got %0d changes expected 0", nchg); end
        checks++; if (md !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", md); end
        checks++; if (ne != 0) begin errors++; $display("FAIL load_addrerr: got %0d expected 0", ne); end
        rdata_a = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (md_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_hold: got %h expected deadbeef", md_a); end
    endtask

    task automatic test_store();
        int ns, nc, nw, ne, nchg, nwd; logic [29:0] fa; logic [31:0] md; bit to;
        rdata_a = 32'h5555_5555;
        access_a(1'b1, 32'h0000_0020, 32'h1234_5678, ns, nc, nw, ne, nchg, nwd, fa, md, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL store_timeout: got %b expected 0", to); end
        checks++; if (nw != 3) begin errors++; $display("FAIL store_we_len: got %0d expected 3", nw); end
        checks++; if (ns != 4) begin errors++; $display("FAIL store_stall_len: got %0d expected 4", ns); end
        checks++; if (nwd != 0) begin errors++; $display("FAIL store_wdata: got %0d bad cycles expected 0", nwd); end
        checks++; if (fa !== 30'h8) begin errors++; $display("FAIL store_addr: got %h expected 8", fa); end
        checks++; if (md !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_memdatai: got %h expected deadbeef", md); end
    endtask

    task automatic test_misaligned();
        int ns, nc, nw, ne, nchg, nwd; logic [29:0] fa; logic [31:0] md; bit to;
        rdata_a = 32'h0BAD_F00D;
        access_a(1'b0, 32'h0000_0013, 32'h0, ns, nc, nw, ne, nchg, nwd, fa, md, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL misal_timeout: got %b expected 0", to); end
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        checks++; if (nc != 0) begin errors++; $display("FAIL misal_ce: got %0d expected 0", nc); end
        checks++; if (ne != 1) begin errors++; $display("FAIL misal_addrerr: got %0d expected 1", ne); end
        checks++; if (ns != 1) begin errors++; $display("FAIL misal_stall: got %0d expected 1", ns); end
        checks++; if (md !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misal_memdatai: got %h expected deadbeef", md); end
`else
        checks++; if (nc != 3) begin errors++; $display("FAIL misal_ce: got %0d expected 3", nc); end
        checks++; if (fa !== 30'h4) begin errors++; $display("FAIL misal_addr: got %h expected 4", fa); end
        checks++; if (ne != 0) begin errors++; $display("FAIL misal_addrerr: got %0d expected 0", ne); end
        checks++; if (ns != 4) begin errors++; $display("FAIL misal_stall: got %0d expected 4", ns); end
        checks++; if (md !== 32'h0BAD_F00D) begin errors++; $display("FAIL misal_memdatai: got %h expected 0badf00d", md); end
`endif
    endtask

    task automatic test_reset_abort();
        int ns, nc, nw, ne, nchg, nwd; logic [29:0] fa; logic [31:0] md; bit to;
        req_a = 1'b1; sorl_a = 1'b1; daddr_a = 32'h40; datao_a = 32'hA5A5_A5A5;
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL abort_pre_we: got %b expected 1", we_a); end
        reset = 1'b0; req_a = 1'b0;
        #1;
        checks++; if ({we_a, ce_a} !== 2'b00) begin errors++; $display("FAIL abort_we_ce: got %b expected 00", {we_a, ce_a}); end
        checks++; if (md_a !== 32'h0) begin errors++; $display("FAIL abort_memdatai: got %h expected 0", md_a); end
        checks++; if ({stall_a, addr_a, wdata_a} !== '0) begin
            errors++; $display("FAIL abort_idle: got stall=%b addr=%h wd=%h expected 0", stall_a, addr_a, wdata_a);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rdata_a = 32'h600D_CAFE;
        access_a(1'b0, 32'h0000_0044, 32'h0, ns, nc, nw, ne, nchg, nwd, fa, md, to);
        checks++; if (ns != 4 || to) begin errors++; $display("FAIL post_reset_stall: got %0d expected 4", ns); end
        checks++; if (md !== 32'h600D_CAFE) begin errors++; $display("FAIL post_reset_load: got %h expected 600dcafe", md); end
        checks++; if (fa !== 30'h11) begin errors++; $display("FAIL post_reset_addr: got %h expected 11", fa); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] st_v, ce_v, we_v;
        logic [31:0] md_last;
        int w0;
        w0 = n_writes_b;
        for (int c = 0; c < 6; c++) begin
            req_b   = 1'b1;
            sorl_b  = (c < 3);
            daddr_b = 32'h20;
            datao_b = (c < 3) ? 32'hCAFE_F00D : 32'h0;
            #1;
            st_v[5-c] = stall_b;
            ce_v[5-c] = ce_b;
            we_v[5-c] = we_b;
            md_last   = md_b;
            @(negedge clk);
        end
        req_b = 1'b0;
        checks++; if (st_v !== 6'b110110) begin errors++; $display("FAIL b2b_stall: got %b expected 110110", st_v); end
        checks++; if (ce_v !== 6'b010010) begin errors++; $display("FAIL b2b_ce: got %b expected 010010", ce_v); end
        checks++; if (we_v !== 6'b010000) begin errors++; $display("FAIL b2b_we: got %b expected 010000", we_v); end
        checks++; if (md_last !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_load: got %h expected cafef00d", md_last); end
        checks++; if (n_writes_b - w0 != 1) begin errors++; $display("FAIL b2b_writes: got %0d expected 1", n_writes_b - w0); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000ns");
        $fatal(1);
    end

endmodule
